// File: rtl/aemb2_cwb_fifo_if.sv
// Bus and stream signals of the FSL-style FIFO bridge.
// Signal names keep the bridge's point of view: _i is driven into the bridge, _o out of it.
interface aemb2_cwb_fifo_if;
  logic        cwb_stb_i;
  logic        cwb_wre_i;
  logic [6:2]  cwb_adr_i;
  logic [1:0]  cwb_tga_i;
  logic [3:0]  cwb_sel_i;
  logic [31:0] cwb_dat_i;
  logic [31:0] cwb_dat_o;
  logic        cwb_ack_o;
  logic        cwb_ctl_o;
  logic [31:0] tx_dat_o;
  logic        tx_ctl_o;
  logic        tx_vld_o;
  logic        tx_rdy_i;
  logic [31:0] rx_dat_i;
  logic        rx_ctl_i;
  logic        rx_vld_i;
  logic        rx_rdy_o;

  modport slave (
    input  cwb_stb_i, cwb_wre_i, cwb_adr_i, cwb_tga_i, cwb_sel_i, cwb_dat_i,
    output cwb_dat_o, cwb_ack_o, cwb_ctl_o,
    output tx_dat_o, tx_ctl_o, tx_vld_o,
    input  tx_rdy_i,
    input  rx_dat_i, rx_ctl_i, rx_vld_i,
    output rx_rdy_o
  );

  modport master (
    output cwb_stb_i, cwb_wre_i, cwb_adr_i, cwb_tga_i, cwb_sel_i, cwb_dat_i,
    input  cwb_dat_o, cwb_ack_o, cwb_ctl_o,
    input  tx_dat_o, tx_ctl_o, tx_vld_o,
    output tx_rdy_i,
    output rx_dat_i, rx_ctl_i, rx_vld_i,
    input  rx_rdy_o
  );
endinterface

// File: rtl/aemb2_cwb_fifo.sv
// Core FSL bus bridge: channel 0 PUTs feed a TX FIFO, GETs drain an RX FIFO.
// Stream sides run independently; all readiness comes from registered counts.
module aemb2_cwb_fifo #(
  parameter int unsigned AW = 2
) (
  input logic              sys_clk_i,
  input logic              sys_rst_i,
  aemb2_cwb_fifo_if.slave  bus_io
);

  localparam int unsigned Depth   = 2 ** AW;
  localparam logic [AW:0] CntFull = (AW + 1)'(Depth);

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

  state_e          r_state;
  state_e          w_state_nxt;
  logic [32:0]     r_tx_mem [Depth];
  logic [32:0]     r_rx_mem [Depth];
  logic [AW-1:0]   r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
  logic [AW:0]     r_tx_cnt, r_rx_cnt;
  logic            r_rst_dly;
  logic            r_ack;
  logic            r_ctl;
  logic [31:0]     r_dat;

  logic            w_map, w_ready, w_hit, w_do;
  logic            w_tx_vld, w_rx_rdy;
  logic            w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
  logic            w_ctl_nxt;
  logic [31:0]     w_dat_nxt;
  logic            w_unused_sel;

  assign w_unused_sel = ^bus_io.cwb_sel_i;

  assign w_tx_vld = (r_tx_cnt != '0);
  // Held low for the cycle following reset so nothing is accepted mid-reset.
  assign w_rx_rdy = !r_rst_dly && (r_rx_cnt != CntFull);

  assign bus_io.tx_vld_o               = w_tx_vld;
  assign bus_io.rx_rdy_o               = w_rx_rdy;
  assign {bus_io.tx_ctl_o, bus_io.tx_dat_o} = r_tx_mem[r_tx_rp];
  assign bus_io.cwb_ack_o              = r_ack;
  assign bus_io.cwb_dat_o              = r_dat;
  assign bus_io.cwb_ctl_o              = r_ctl;

  assign w_tx_pop  = w_tx_vld & bus_io.tx_rdy_i;
  assign w_rx_push = bus_io.rx_vld_i & w_rx_rdy;

  assign w_map   = (bus_io.cwb_adr_i == '0);
  assign w_ready = bus_io.cwb_wre_i ? (r_tx_cnt != CntFull) : (r_rx_cnt != '0);
  assign w_hit   = w_map & w_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_do        = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (bus_io.cwb_stb_i) begin
          if (w_hit || !w_map || bus_io.cwb_tga_i[0]) begin
            w_state_nxt = StAck;
            w_do        = w_hit;
          end else begin
            w_state_nxt = StWait;
          end
        end
      end
      StWait: begin
        if (!bus_io.cwb_stb_i) begin
          w_state_nxt = StIdle;
        end else if (w_hit || !w_map) begin
          w_state_nxt = StAck;
          w_do        = w_hit;
        end
      end
      StAck:   w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  assign w_tx_push = w_do & bus_io.cwb_wre_i;
  assign w_rx_pop  = w_do & !bus_io.cwb_wre_i;

  // Failed or unmapped transfers return zero.
  always_comb begin
    w_ctl_nxt = 1'b0;
    w_dat_nxt = '0;
    if (w_rx_pop) begin
      {w_ctl_nxt, w_dat_nxt} = r_rx_mem[r_rx_rp];
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      r_state   <= StIdle;
      r_ack     <= 1'b0;
      r_dat     <= '0;
      r_ctl     <= 1'b0;
      r_rst_dly <= 1'b1;
      r_tx_wp   <= '0;
      r_tx_rp   <= '0;
      r_tx_cnt  <= '0;
      r_rx_wp   <= '0;
      r_rx_rp   <= '0;
      r_rx_cnt  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ack     <= (w_state_nxt == StAck);
      r_dat     <= w_dat_nxt;
      r_ctl     <= w_ctl_nxt;
      r_rst_dly <= 1'b0;
      r_tx_wp   <= r_tx_wp + AW'(w_tx_push);
      r_tx_rp   <= r_tx_rp + AW'(w_tx_pop);
      r_tx_cnt  <= r_tx_cnt + {{AW{1'b0}}, w_tx_push} - {{AW{1'b0}}, w_tx_pop};
      r_rx_wp   <= r_rx_wp + AW'(w_rx_push);
      r_rx_rp   <= r_rx_rp + AW'(w_rx_pop);
      r_rx_cnt  <= r_rx_cnt + {{AW{1'b0}}, w_rx_push} - {{AW{1'b0}}, w_rx_pop};
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_i && w_tx_push) begin
      r_tx_mem[r_tx_wp] <= {bus_io.cwb_tga_i[1], bus_io.cwb_dat_i};
    end
    if (!sys_rst_i && w_rx_push) begin
      r_rx_mem[r_rx_wp] <= {bus_io.rx_ctl_i, bus_io.rx_dat_i};
    end
  end

endmodule

// File: tb/tb_aemb2_cwb_fifo.sv
// Scoreboard bench for aemb2_cwb_fifo: directed scenarios then random bus/stream traffic.
module tb_aemb2_cwb_fifo;

  localparam int Depth = 4;

  typedef struct packed {
    logic        chk;
    logic        ctl;
    logic [31:0] dat;
  } resp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  resp_t       exp_q [$];
  logic [32:0] tx_q  [$];
  logic [32:0] rx_q  [$];
  resp_t       mon_r;
  logic [32:0] mon_w;

  aemb2_cwb_fifo_if u_if ();

  aemb2_cwb_fifo #(.AW(2)) u_dut (
    .sys_clk_i (clk),
    .sys_rst_i (rst),
    .bus_io    (u_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: bus responses against the scoreboard, TX stream against the model queue.
  always @(negedge clk) begin
    if (u_if.cwb_ack_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack actual=1 required=0");
      end else begin
        mon_r = exp_q.pop_front();
        if (mon_r.chk) check("get_data", {u_if.cwb_ctl_o, u_if.cwb_dat_o}, {mon_r.ctl, mon_r.dat});
      end
    end
    if (u_if.tx_vld_o === 1'b1 && u_if.tx_rdy_i === 1'b1) begin
      if (tx_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_underflow actual=1 required=0");
      end else begin
        mon_w = tx_q.pop_front();
        check("tx_stream", {u_if.tx_ctl_o, u_if.tx_dat_o}, mon_w);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bus transfer the model knows will complete at once; optional concurrent stream beat.
  task automatic bus_xfer(input bit wre, input logic [4:0] adr, input logic [1:0] tga,
                          input logic [31:0] dat, input bit strm);
    resp_t       r;
    bit          rdy;
    bit          acc;
    logic [32:0] w;
    int          n;
    r.chk = !wre || (adr != 0);
    r.ctl = 1'b0;
    r.dat = '0;
    rdy   = 1'b0;
    acc   = 1'b0;
    w     = {1'($urandom), 32'($urandom)};
    if (adr == 0) begin
      rdy = wre ? (tx_q.size() < Depth) : (rx_q.size() > 0);
      if (!rdy) tga[0] = 1'b1;
    end
    u_if.cwb_stb_i = 1'b1;
    u_if.cwb_wre_i = wre;
    u_if.cwb_adr_i = adr;
    u_if.cwb_tga_i = tga;
    u_if.cwb_sel_i = 4'($urandom);
    u_if.cwb_dat_i = dat;
    if (strm) begin
      if (wre) begin
        u_if.tx_rdy_i = 1'b1;
      end else begin
        acc = (rx_q.size() < Depth);
        check("rx_rdy_xfer", 64'(u_if.rx_rdy_o), 64'(acc));
        {u_if.rx_ctl_i, u_if.rx_dat_i} = w;
        u_if.rx_vld_i = 1'b1;
      end
    end
    if ((adr == 0) && rdy) begin
      if (wre) tx_q.push_back({tga[1], dat});
      else {r.ctl, r.dat} = rx_q.pop_front();
    end
    if (acc) rx_q.push_back(w);
    exp_q.push_back(r);
    n = 0;
    do begin
      tick();
      n++;
      u_if.tx_rdy_i = 1'b0;
      u_if.rx_vld_i = 1'b0;
    end while (u_if.cwb_ack_o !== 1'b1 && n < 8);
    check("bus_latency", 64'(n), 64'(1));
    u_if.cwb_stb_i = 1'b0;
    tick();
  endtask

  task automatic rx_send(input logic [32:0] w);
    bit acc;
    acc = (rx_q.size() < Depth);
    check("rx_rdy", 64'(u_if.rx_rdy_o), 64'(acc));
    {u_if.rx_ctl_i, u_if.rx_dat_i} = w;
    u_if.rx_vld_i = 1'b1;
    if (acc) rx_q.push_back(w);
    tick();
    u_if.rx_vld_i = 1'b0;
  endtask

  task automatic tx_take();
    check("tx_vld", 64'(u_if.tx_vld_o), 64'(tx_q.size() != 0));
    u_if.tx_rdy_i = 1'b1;
    tick();
    u_if.tx_rdy_i = 1'b0;
  endtask

  initial begin
    int   n;
    bit   seen;
    logic [4:0] adr;
    u_if.cwb_stb_i = 1'b0;
    u_if.cwb_wre_i = 1'b0;
    u_if.cwb_adr_i = '0;
    u_if.cwb_tga_i = '0;
    u_if.cwb_sel_i = '0;
    u_if.cwb_dat_i = '0;
    u_if.tx_rdy_i  = 1'b0;
    u_if.rx_dat_i  = '0;
    u_if.rx_ctl_i  = 1'b0;
    u_if.rx_vld_i  = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_ack", 64'(u_if.cwb_ack_o), 64'(0));
    check("rst_dat", {31'd0, u_if.cwb_ctl_o, u_if.cwb_dat_o}, 64'(0));
    check("rst_tx_vld", 64'(u_if.tx_vld_o), 64'(0));
    check("rst_rx_rdy", 64'(u_if.rx_rdy_o), 64'(0));
    rst = 1'b0;
    tick();
    tick();
    check("post_rst_rx_rdy", 64'(u_if.rx_rdy_o), 64'(1));

    // Blocking PUT with control flag
    bus_xfer(1'b1, 5'd0, 2'b10, 32'hDEADBEEF, 1'b0);
    check("put_tx_vld", 64'(u_if.tx_vld_o), 64'(1));
    check("put_tx_head", {u_if.tx_ctl_o, u_if.tx_dat_o}, {1'b1, 32'hDEADBEEF});
    tx_take();

    // Blocking GET on empty RX, data arrives later
    exp_q.push_back('{chk: 1'b1, ctl: 1'b0, dat: 32'h12345678});
    u_if.cwb_stb_i = 1'b1;
    u_if.cwb_wre_i = 1'b0;
    u_if.cwb_adr_i = '0;
    u_if.cwb_tga_i = 2'b00;
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (u_if.cwb_ack_o === 1'b1) seen = 1'b1;
    end
    check("get_wait_no_ack", 64'(seen), 64'(0));
    {u_if.rx_ctl_i, u_if.rx_dat_i} = {1'b0, 32'h12345678};
    u_if.rx_vld_i = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
      u_if.rx_vld_i = 1'b0;
    end while (u_if.cwb_ack_o !== 1'b1 && n < 10);
    check("get_wait_latency", 64'(n), 64'(2));
    u_if.cwb_stb_i = 1'b0;
    tick();

    // Non-blocking GET on empty RX, twice to show nothing was consumed or invented
    bus_xfer(1'b0, 5'd0, 2'b01, 32'h0, 1'b0);
    bus_xfer(1'b0, 5'd0, 2'b01, 32'h0, 1'b0);
    check("nb_get_rx_rdy", 64'(u_if.rx_rdy_o), 64'(1));

    // Fill TX, fifth PUT waits until one word drains, then the stream wraps
    for (int i = 1; i <= 4; i++) bus_xfer(1'b1, 5'd0, 2'b00, 32'(i), 1'b0);
    exp_q.push_back('{chk: 1'b0, ctl: 1'b0, dat: 32'h0});
    u_if.cwb_stb_i = 1'b1;
    u_if.cwb_wre_i = 1'b1;
    u_if.cwb_tga_i = 2'b00;
    u_if.cwb_dat_i = 32'd5;
    seen = 1'b0;
    repeat (3) begin
      tick();
      if (u_if.cwb_ack_o === 1'b1) seen = 1'b1;
    end
    check("full_put_waits", 64'(seen), 64'(0));
    u_if.tx_rdy_i = 1'b1;
    n = 0;
    do begin
      tick();
      if (n == 0) tx_q.push_back({1'b0, 32'd5});
      n++;
      u_if.tx_rdy_i = 1'b0;
    end while (u_if.cwb_ack_o !== 1'b1 && n < 10);
    check("full_put_latency", 64'(n), 64'(2));
    u_if.cwb_stb_i = 1'b0;
    tick();
    repeat (4) tx_take();
    check("tx_drained", 64'(u_if.tx_vld_o), 64'(0));

    // Abort a waiting GET
    u_if.cwb_stb_i = 1'b1;
    u_if.cwb_wre_i = 1'b0;
    u_if.cwb_tga_i = 2'b00;
    seen = 1'b0;
    repeat (3) begin
      tick();
      if (u_if.cwb_ack_o === 1'b1) seen = 1'b1;
    end
    u_if.cwb_stb_i = 1'b0;
    repeat (3) begin
      tick();
      if (u_if.cwb_ack_o === 1'b1) seen = 1'b1;
    end
    check("abort_no_ack", 64'(seen), 64'(0));
    bus_xfer(1'b0, 5'd0, 2'b01, 32'h0, 1'b0);

    // Reset with buffered RX words
    for (int i = 0; i < 3; i++) rx_send({1'b1, 32'hA000_0000 + 32'(i)});
    rst = 1'b1;
    tick();
    check("mid_rst_rx_rdy", 64'(u_if.rx_rdy_o), 64'(0));
    tick();
    check("mid_rst_ack", 64'(u_if.cwb_ack_o), 64'(0));
    rx_q.delete();
    tx_q.delete();
    rst = 1'b0;
    tick();
    tick();
    check("after_rst_rx_rdy", 64'(u_if.rx_rdy_o), 64'(1));
    bus_xfer(1'b0, 5'd0, 2'b01, 32'h0, 1'b0);

    // Unmapped channel
    bus_xfer(1'b1, 5'd5, 2'b00, 32'hCAFEF00D, 1'b0);
    check("unmapped_tx_vld", 64'(u_if.tx_vld_o), 64'(0));
    rx_send({1'b0, 32'h55AA55AA});
    bus_xfer(1'b0, 5'd5, 2'b00, 32'h0, 1'b0);

    // Random traffic
    for (int it = 0; it < 400; it++) begin
      adr = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      case ($urandom_range(0, 5))
        0, 1:    bus_xfer(1'b1, adr, 2'($urandom), 32'($urandom), 1'($urandom));
        2, 3:    bus_xfer(1'b0, adr, 2'($urandom), 32'($urandom), 1'($urandom));
        4:       rx_send({1'($urandom), 32'($urandom)});
        default: tx_take();
      endcase
    end
    repeat (2) tick();
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aemb2_cwb_fifo.md
AEMB2_CWB_FIFO -- requirements
Module: aemb2_cwb_fifo

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter AW SHALL default to 2 and SHALL set the FIFO depth to 2**AW entries per direction.
REQ-003 Port sys_clk_i SHALL be an input, 1 bit wide: the system clock; all state updates on its rising edge.
REQ-004 Port sys_rst_i SHALL be an input, 1 bit wide: synchronous, active-high reset.
REQ-005 Port cwb_stb_i SHALL be an input, 1 bit wide: the core's FSL bus strobe, held high until ack.
REQ-006 Port cwb_wre_i SHALL be an input, 1 bit wide: 1 = PUT (core to FIFO), 0 = GET (FIFO to core).
REQ-007 Port cwb_adr_i SHALL be an input, 5 bits wide ([6:2]): channel number.
REQ-008 Port cwb_tga_i SHALL be an input, 2 bits wide: [1] is the control flag and [0] is the non-blocking flag.
REQ-009 Port cwb_sel_i SHALL be an input, 4 bits wide: byte select; ignored, full-word transfers only.
REQ-010 Port cwb_dat_i SHALL be an input, 32 bits wide: PUT data.
REQ-011 Port cwb_dat_o SHALL be an output, 32 bits wide: GET data, registered.
REQ-012 Port cwb_ack_o SHALL be an output, 1 bit wide: transfer acknowledge, registered, one-cycle pulse.
REQ-013 Port cwb_ctl_o SHALL be an output, 1 bit wide: control bit of the popped GET word, valid with ack.
REQ-014 Port tx_dat_o SHALL be an output, 32 bits wide: outbound stream data (TX FIFO head).
REQ-015 Port tx_ctl_o SHALL be an output, 1 bit wide: outbound control bit.
REQ-016 Port tx_vld_o SHALL be an output, 1 bit wide: TX FIFO is not empty.
REQ-017 Port tx_rdy_i SHALL be an input, 1 bit wide: the downstream consumer accepts the head word.
REQ-018 Port rx_dat_i SHALL be an input, 32 bits wide: inbound stream data.
REQ-019 Port rx_ctl_i SHALL be an input, 1 bit wide: inbound control bit.
REQ-020 Port rx_vld_i SHALL be an input, 1 bit wide: the inbound word is valid.
REQ-021 Port rx_rdy_o SHALL be an output, 1 bit wide: RX FIFO is not full.

Function
REQ-022 Each FIFO entry SHALL hold 33 bits ({ctl, data}) and SHALL keep an occupancy count AW+1 bits wide; read and write pointers SHALL wrap modulo 2**AW.
REQ-023 The bus FSM SHALL have three states: IDLE, WAIT and ACK.
REQ-024 Channel 0 (cwb_adr_i == 0) SHALL map to the FIFOs; any other channel SHALL ack from IDLE with cwb_dat_o = 0 and cwb_ctl_o = 0, discard writes and leave the FIFOs unchanged.
REQ-025 A transfer is "ready" when it is a PUT with the TX FIFO not full, or a GET with the RX FIFO not empty.
REQ-026 IDLE with stb and ready SHALL go to ACK on the next edge.
- PUT: push {tga[1], cwb_dat_i} on that edge.
- GET: pop on that edge and register the head into cwb_dat_o/cwb_ctl_o.
- Result: cwb_ack_o = 1 one cycle after stb is sampled.
REQ-027 IDLE with stb, not ready and tga[0] = 1 (non-blocking) SHALL go to ACK without any FIFO change; a failed GET returns cwb_dat_o = 0 and cwb_ctl_o = 0.
REQ-028 IDLE with stb, not ready and tga[0] = 0 SHALL go to WAIT, holding cwb_ack_o = 0.
REQ-029 WAIT SHALL perform the IDLE-ready action and go to ACK once ready; if stb drops it SHALL return to IDLE with no FIFO change (abort).
REQ-030 ACK SHALL last exactly one cycle, ignore stb and always return to IDLE; back-to-back transfers therefore SHALL take at least 2 cycles each.
REQ-031 The stream side SHALL be independent of the bus side.
- TX pop when tx_vld_o & tx_rdy_i.
- RX push when rx_vld_i & rx_rdy_o.
- A core PUT/GET may occur on the same edge as a stream pop/push; counts SHALL update by the net change.
REQ-032 tx_vld_o and rx_rdy_o SHALL be derived from registered counts only, with no combinational path from any input.
REQ-033 On a simultaneous stream pop and core PUT on a full TX FIFO, the PUT SHALL NOT occur that edge; readiness SHALL use the registered count only.
REQ-034 tx_dat_o/tx_ctl_o SHALL show the TX head whenever tx_vld_o = 1; they are don't-care when empty.

Reset
REQ-035 While sys_rst_i is high at an edge, the FSM SHALL go to IDLE, all pointers and counts SHALL clear, and cwb_ack_o, cwb_dat_o and cwb_ctl_o SHALL be 0.
REQ-036 During reset tx_vld_o = 0 and rx_rdy_o = 0; rx_rdy_o = 1 from the first cycle after reset.
REQ-037 Reset asserted in WAIT or ACK SHALL abort the transfer with no ack and no FIFO update.

Verification
REQ-038 Blocking PUT: PUT 0xDEADBEEF, tga = 2'b10, tx_rdy_i = 0 -> ack exactly 1 cycle later; tx_vld_o = 1, tx_dat_o = 0xDEADBEEF, tx_ctl_o = 1.
REQ-039 Blocking GET on empty: GET with tga = 0 and RX empty for 5 cycles, then rx 0x12345678 presented -> ack 2 cycles after rx_vld_i, cwb_dat_o = 0x12345678.
REQ-040 Non-blocking GET on empty: tga = 2'b01 -> ack after 1 cycle, cwb_dat_o = 0, RX count stays 0.
REQ-041 Full/wrap: fill TX with 4 PUTs (values 1..4) -> 5th blocking PUT stays in WAIT; one tx_rdy_i pulse pops 1 -> 5th PUT acks; the stream then yields 2, 3, 4, 5 across the pointer wrap.
REQ-042 Abort and reset: drop stb in WAIT -> no ack, counts unchanged; assert sys_rst_i with 3 RX words buffered -> rx count 0, rx_rdy_o = 0 during reset and 1 after.
REQ-043 Unmapped channel: PUT to channel 5 -> ack after 1 cycle, TX count unchanged.
